regfile_mp_scoreboard: RTL and testbench

- Parametrised multi-port successor to the CPU's single-write register file.
- Provides NUM_RD combinational read ports and NUM_WR write ports, with write-to-read bypass, a hardwired-zero x0 and an asynchronous clear.
- Adds a per-register pending (scoreboard) bit: the issue stage marks a destination pending and a writeback clears it, so decode can detect RAW hazards against in-flight writes.
- Sits between decode/issue and the writeback stage of the pipelined core.

---
 rtl/regfile_mp_scoreboard.sv | 124 ++++++++++++
 tb/tb_regfile_mp_scoreboard.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file with write-to-read bypass, hardwired-zero x0,
// asynchronous clear, and a per-register pending (scoreboard) bit.
//
// Ports:
//   clk, rstn     clock, asynchronous active-low reset
//   rdAddr        NUM_RD packed read addresses
//   rdData        NUM_RD packed read data (combinational)
//   rdReady       per read port: operand final (not pending, or bypassed)
//   wrEn/wrAddr/wrData  NUM_WR write ports, higher index wins
//   issueEn/issueAddr   mark a destination register pending
//   pending       registered pending vector (bit 0 always 0)
//   pendCnt       registered popcount of pending
module regfile_mp_scoreboard #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_RD*ADDR_W-1:0]   rdAddr,
    output logic [NUM_RD*DATA_W-1:0]   rdData,
    output logic [NUM_RD-1:0]          rdReady,
    input  logic [NUM_WR-1:0]          wrEn,
    input  logic [NUM_WR*ADDR_W-1:0]   wrAddr,
    input  logic [NUM_WR*DATA_W-1:0]   wrData,
    input  logic                       issueEn,
    input  logic [ADDR_W-1:0]          issueAddr,
    output logic [(2**ADDR_W)-1:0]     pending,
    output logic [ADDR_W:0]            pendCnt
);

    localparam int unsigned NREG  = 2**ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_pending;
    logic [CNT_W-1:0]  r_pend_cnt;

    logic [NREG-1:0]   w_wr_hit;
    logic [DATA_W-1:0] w_wr_val [NREG];
    logic [NREG-1:0]   w_pend_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ADDR_W-1:0] w_rd_addr [NUM_RD];

    // Per-address write resolution; ascending port scan lets the highest index win.
    always_comb begin
        for (int a = 0; a < int'(NREG); a++) begin
            w_wr_hit[a] = 1'b0;
            w_wr_val[a] = '0;
            for (int p = 0; p < int'(NUM_WR); p++) begin
                if (wrEn[p] && (wrAddr[p*ADDR_W +: ADDR_W] == ADDR_W'(a))) begin
                    w_wr_hit[a] = 1'b1;
                    w_wr_val[a] = wrData[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Next pending state: issue beats writeback, since a new producer supersedes the old.
    always_comb begin
        w_pend_nxt = '0;
        w_cnt_nxt  = '0;
        for (int a = 1; a < int'(NREG); a++) begin
            if (issueEn && (issueAddr == ADDR_W'(a))) begin
                w_pend_nxt[a] = 1'b1;
            end else if (w_wr_hit[a]) begin
                w_pend_nxt[a] = 1'b0;
            end else begin
                w_pend_nxt[a] = r_pending[a];
            end
            w_cnt_nxt = w_cnt_nxt + CNT_W'(w_pend_nxt[a]);
        end
    end

    // Combinational read ports with same-cycle write bypass.
    always_comb begin
        rdData  = '0;
        rdReady = '0;
        for (int r = 0; r < int'(NUM_RD); r++) begin
            w_rd_addr[r] = rdAddr[r*ADDR_W +: ADDR_W];
            if (w_rd_addr[r] == '0) begin
                rdData[r*DATA_W +: DATA_W] = '0;
                rdReady[r]                 = 1'b1;
            end else if (w_wr_hit[w_rd_addr[r]]) begin
                rdData[r*DATA_W +: DATA_W] = w_wr_val[w_rd_addr[r]];
                rdReady[r]                 = 1'b1;
            end else begin
                rdData[r*DATA_W +: DATA_W] = r_regs[w_rd_addr[r]];
                rdReady[r]                 = !r_pending[w_rd_addr[r]];
            end
        end
    end

    // Register array; entry 0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int a = 0; a < int'(NREG); a++) begin
                r_regs[a] <= '0;
            end
        end else begin
            for (int a = 1; a < int'(NREG); a++) begin
                if (w_wr_hit[a]) begin
                    r_regs[a] <= w_wr_val[a];
                end
            end
        end
    end

    // Scoreboard state; count is recomputed from next-state so it tracks pending exactly.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pending  <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_pending  <= w_pend_nxt;
            r_pend_cnt <= w_cnt_nxt;
        end
    end

    assign pending = r_pending;
    assign pendCnt = r_pend_cnt;

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed self-checking bench for regfile_mp_scoreboard (default parameters).
module tb_regfile_mp_scoreboard;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned NUM_WR = 2;
    localparam int unsigned NREG   = 32;

    logic                     clk;
    logic                     rstn;
    logic [NUM_RD*ADDR_W-1:0] rdAddr;
    logic [NUM_RD*DATA_W-1:0] rdData;
    logic [NUM_RD-1:0]        rdReady;
    logic [NUM_WR-1:0]        wrEn;
    logic [NUM_WR*ADDR_W-1:0] wrAddr;
    logic [NUM_WR*DATA_W-1:0] wrData;
    logic                     issueEn;
    logic [ADDR_W-1:0]        issueAddr;
    logic [NREG-1:0]          pending;
    logic [ADDR_W:0]          pendCnt;

    int n_checks;
    int n_errors;
    logic [NREG-1:0] exp_pend;

    regfile_mp_scoreboard #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)
    ) dut (
        .clk(clk), .rstn(rstn),
        .rdAddr(rdAddr), .rdData(rdData), .rdReady(rdReady),
        .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .issueEn(issueEn), .issueAddr(issueAddr),
        .pending(pending), .pendCnt(pendCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int p, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wrEn[p]                      = 1'b1;
        wrAddr[p*ADDR_W +: ADDR_W]   = a;
        wrData[p*DATA_W +: DATA_W]   = d;
    endtask

    task automatic clr_in();
        wrEn    = '0;
        wrAddr  = '0;
        wrData  = '0;
        issueEn = 1'b0;
        issueAddr = '0;
    endtask

    task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        rdAddr[0 +: ADDR_W]      = a0;
        rdAddr[ADDR_W +: ADDR_W] = a1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rstn     = 1'b0;
        rdAddr   = '0;
        clr_in();

        // Reset state
        #2;
        set_rd(5'd5, 5'd7);
        #1;
        check("rst_rd0", 64'(rdData[31:0]), 64'h0);
        check("rst_ready", 64'(rdReady), 64'h3);
        check("rst_pend", 64'(pending), 64'h0);
        check("rst_cnt", 64'(pendCnt), 64'h0);
        #5;
        rstn = 1'b1;
        tick();

        // Preload reg 5, issue reg 7, then asynchronous clear mid-cycle
        set_wr(0, 5'd5, 32'hDEADBEEF);
        tick();
        clr_in();
        issueEn = 1'b1; issueAddr = 5'd7;
        tick();
        clr_in();
        check("pre_rd5", 64'(rdData[31:0]), 64'hDEADBEEF);
        check("pre_pend7", 64'(pending[7]), 64'h1);
        check("pre_ready7", 64'(rdReady[1]), 64'h0);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_rd5", 64'(rdData[31:0]), 64'h0);
        check("arst_pend", 64'(pending), 64'h0);
        check("arst_cnt", 64'(pendCnt), 64'h0);
        check("arst_ready", 64'(rdReady), 64'h3);
        #1;
        rstn = 1'b1;
        tick();

        // Dual-write priority
        set_rd(5'd3, 5'd3);
        set_wr(0, 5'd3, 32'h11);
        set_wr(1, 5'd3, 32'h22);
        #1;
        check("prio_byp", 64'(rdData[31:0]), 64'h22);
        check("prio_byp_rdy", 64'(rdReady[0]), 64'h1);
        tick();
        clr_in();
        #1;
        check("prio_reg", 64'(rdData[63:32]), 64'h22);

        // Write to x0 discarded
        set_rd(5'd0, 5'd0);
        set_wr(0, 5'd0, 32'hFFFF);
        #1;
        check("x0_byp", 64'(rdData[31:0]), 64'h0);
        tick();
        clr_in();
        #1;
        check("x0_reg", 64'(rdData[31:0]), 64'h0);
        check("x0_rdy", 64'(rdReady[0]), 64'h1);

        // Bypass over stored value
        set_wr(0, 5'd4, 32'h10);
        tick();
        clr_in();
        set_rd(5'd4, 5'd4);
        #1;
        check("byp_old", 64'(rdData[31:0]), 64'h10);
        set_wr(1, 5'd4, 32'h20);
        #1;
        check("byp_rd0", 64'(rdData[31:0]), 64'h20);
        check("byp_rd1", 64'(rdData[63:32]), 64'h20);
        check("byp_rdy", 64'(rdReady), 64'h3);
        tick();
        clr_in();
        #1;
        check("byp_after", 64'(rdData), {32'h20, 32'h20});

        // Scoreboard set and writeback clear
        issueEn = 1'b1; issueAddr = 5'd9;
        set_rd(5'd9, 5'd4);
        #1;
        check("sb_noissue_path", 64'(rdReady[0]), 64'h1);
        tick();
        clr_in();
        #1;
        check("sb_pend9", 64'(pending), 64'(32'h200));
        check("sb_cnt1", 64'(pendCnt), 64'h1);
        check("sb_rdy9", 64'(rdReady), 64'h2);
        set_wr(0, 5'd9, 32'h55);
        #1;
        check("sb_wb_rdy", 64'(rdReady[0]), 64'h1);
        check("sb_wb_data", 64'(rdData[31:0]), 64'h55);
        tick();
        clr_in();
        #1;
        check("sb_clr_pend", 64'(pending), 64'h0);
        check("sb_clr_cnt", 64'(pendCnt), 64'h0);
        check("sb_clr_rd", 64'(rdData[31:0]), 64'h55);

        // Simultaneous issue and writeback on reg 12
        issueEn = 1'b1; issueAddr = 5'd12;
        tick();
        clr_in();
        issueEn = 1'b1; issueAddr = 5'd12;
        set_wr(1, 5'd12, 32'h77);
        tick();
        clr_in();
        set_rd(5'd12, 5'd12);
        #1;
        check("sim_data", 64'(rdData[31:0]), 64'h77);
        check("sim_pend", 64'(pending), 64'(32'h1000));
        check("sim_cnt", 64'(pendCnt), 64'h1);
        check("sim_rdy", 64'(rdReady), 64'h0);

        // Fill the scoreboard
        exp_pend = 32'h1000;
        for (int i = 1; i < 32; i++) begin
            issueEn = 1'b1; issueAddr = ADDR_W'(i);
            tick();
            exp_pend[i] = 1'b1;
            check($sformatf("fill_cnt_%0d", i), 64'(pendCnt), 64'($countones(exp_pend)));
        end
        clr_in();
        check("fill_pend", 64'(pending), 64'(32'hFFFF_FFFE));
        check("fill_cnt", 64'(pendCnt), 64'd31);
        issueEn = 1'b1; issueAddr = 5'd0;
        tick();
        clr_in();
        check("issue0_pend", 64'(pending), 64'(32'hFFFF_FFFE));
        check("issue0_cnt", 64'(pendCnt), 64'd31);

        // Drain with paired writebacks
        for (int k = 1; k < 32; k += 2) begin
            clr_in();
            set_wr(0, ADDR_W'(k), DATA_W'(k));
            exp_pend[k] = 1'b0;
            if (k + 1 < 32) begin
                set_wr(1, ADDR_W'(k + 1), DATA_W'(k + 1));
                exp_pend[k + 1] = 1'b0;
            end
            tick();
            check($sformatf("drain_pend_%0d", k), 64'(pending), 64'(exp_pend));
            check($sformatf("drain_cnt_%0d", k), 64'(pendCnt), 64'($countones(exp_pend)));
        end
        clr_in();
        check("drain_zero", 64'(pendCnt), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
